// File: rtl/ivl_uvm_mbx_array.sv
// Purpose: NUM_CH bounded FIFO mailboxes merged round-robin onto one registered, channel-tagged get stream.
// Latency: a put reaches out_valid two edges later at minimum (write edge, then arbitration/load edge).
// Backpressure: put_ready[c] drops only when channel c is full or flushing; out_ready low freezes the output register.
//
// Ports:
//   clk, rst                    clock (rising edge), asynchronous active-high reset
//   put_valid/put_ready/put_data per-channel put handshake; channel c data at [c*WIDTH +: WIDTH]
//   flush                       per-channel synchronous clear (pointers and occupancy)
//   out_valid/out_ready/out_data/out_ch  merged get stream with source channel tag
//   count, empty, full          per-channel occupancy (output register excluded) and flags
//   wmark                       per-channel high-water mark of count, only with IVL_UVM_MBX_WMARK_EN defined
module ivl_uvm_mbx_array #(
  parameter  int WIDTH  = 32,
  parameter  int DEPTH  = 8,
  parameter  int NUM_CH = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        put_valid,
  output logic [NUM_CH-1:0]        put_ready,
  input  logic [NUM_CH*WIDTH-1:0]  put_data,
  input  logic [NUM_CH-1:0]        flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [CW-1:0]            out_ch,
  output logic [NUM_CH*(AW+1)-1:0] count,
  output logic [NUM_CH-1:0]        empty,
  output logic [NUM_CH-1:0]        full
`ifdef IVL_UVM_MBX_WMARK_EN
  ,
  output logic [NUM_CH*(AW+1)-1:0] wmark
`endif
);

  logic [WIDTH-1:0]  mem     [NUM_CH][DEPTH];
  logic [AW-1:0]     wptr    [NUM_CH];
  logic [AW-1:0]     rptr    [NUM_CH];
  logic [AW:0]       cnt     [NUM_CH];
  logic [AW:0]       cnt_nxt [NUM_CH];

  logic [NUM_CH-1:0] push_vld;
  logic [NUM_CH-1:0] pop_vld;
  logic [NUM_CH-1:0] elig;
  logic [CW-1:0]     last;
  logic [CW-1:0]     win;
  logic              win_vld;
  logic              load;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign empty[c]     = (cnt[c] == '0);
    assign full[c]      = (cnt[c] == (AW+1)'(DEPTH));
    assign put_ready[c] = !full[c] && !flush[c];
    assign push_vld[c]  = put_valid[c] && put_ready[c];
    // Occupancy is registered, so a word written this edge only becomes
    // eligible on the following one. A flushing channel sits out arbitration.
    assign elig[c]      = !empty[c] && !flush[c];
    assign count[c*(AW+1) +: AW+1] = cnt[c];
    assign cnt_nxt[c]   = flush[c] ? '0
                        : cnt[c] + (AW+1)'(push_vld[c]) - (AW+1)'(pop_vld[c]);
  end

  assign load = !out_valid || out_ready;

  // Round-robin: scan last+1, last+2, ... and take the first eligible channel.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win     = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last) + i) % NUM_CH;
      if (!win_vld && elig[idx]) begin
        win_vld = 1'b1;
        win     = CW'(idx);
      end
    end
  end

  always_comb begin
    pop_vld = '0;
    if (load && win_vld) pop_vld[win] = 1'b1;
  end

  // Storage has no reset; pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push_vld[c]) mem[c][wptr[c]] <= put_data[c*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr[c] <= '0;
        rptr[c] <= '0;
        cnt[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (flush[c]) begin
          wptr[c] <= '0;
          rptr[c] <= '0;
        end else begin
          if (push_vld[c]) wptr[c] <= wptr[c] + AW'(1);
          if (pop_vld[c])  rptr[c] <= rptr[c] + AW'(1);
        end
        cnt[c] <= cnt_nxt[c];
      end
    end
  end

  // Output register: reloads whenever empty or being consumed; clears when
  // consumed with nothing left to send. Flush never touches it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      last      <= CW'(NUM_CH - 1);
    end else if (load) begin
      if (win_vld) begin
        out_valid <= 1'b1;
        out_data  <= mem[win][rptr[win]];
        out_ch    <= win;
        last      <= win;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef IVL_UVM_MBX_WMARK_EN
  logic [AW:0] wm [NUM_CH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) wm[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (flush[c])                wm[c] <= '0;
        else if (cnt_nxt[c] > wm[c]) wm[c] <= cnt_nxt[c];
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_wm
    assign wmark[c*(AW+1) +: AW+1] = wm[c];
  end
`endif

endmodule

// File: tb/tb_ivl_uvm_mbx_array.sv
// Directed bench for ivl_uvm_mbx_array (WIDTH=32, DEPTH=8, NUM_CH=4).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// Build with IVL_UVM_MBX_WMARK_EN defined to also cover the high-water mark.
module tb_ivl_uvm_mbx_array;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 8;
  localparam int NUM_CH = 4;
  localparam int AW1    = 4;

  logic                    clk;
  logic                    rst;
  logic [NUM_CH-1:0]       put_valid;
  logic [NUM_CH-1:0]       put_ready;
  logic [NUM_CH*WIDTH-1:0] put_data;
  logic [NUM_CH-1:0]       flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [1:0]              out_ch;
  logic [NUM_CH*AW1-1:0]   count;
  logic [NUM_CH-1:0]       empty;
  logic [NUM_CH-1:0]       full;
`ifdef IVL_UVM_MBX_WMARK_EN
  logic [NUM_CH*AW1-1:0]   wmark;
`endif

  int checks   = 0;
  int failures = 0;

  ivl_uvm_mbx_array #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .put_valid (put_valid),
    .put_ready (put_ready),
    .put_data  (put_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .count     (count),
    .empty     (empty),
    .full      (full)
`ifdef IVL_UVM_MBX_WMARK_EN
    ,
    .wmark     (wmark)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW1-1:0] cnt_of(input int c);
    return count[c*AW1 +: AW1];
  endfunction

`ifdef IVL_UVM_MBX_WMARK_EN
  function automatic logic [AW1-1:0] wm_of(input int c);
    return wmark[c*AW1 +: AW1];
  endfunction
`endif

  task automatic do_reset();
    put_valid = '0;
    put_data  = '0;
    flush     = '0;
    out_ready = 1'b0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; put_valid = '0; put_data = '0; flush = '0; out_ready = 1'b0;

    // Reset then idle
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 4'b1111);
    chk("rst_full", full, 0);
    chk("rst_put_ready", put_ready, 4'b1111);
    chk("rst_out_ch", out_ch, 0);

    // Single word on ch2: two-edge latency
    out_ready = 1'b1;
    put_valid = 4'b0100;
    put_data[2*WIDTH +: WIDTH] = 32'hA0;
    tick();
    put_valid = '0;
    chk("lat_edge1_valid", out_valid, 0);
    chk("lat_edge1_cnt2", cnt_of(2), 1);
    tick();
    chk("lat_edge2_valid", out_valid, 1);
    chk("lat_edge2_data", out_data, 32'hA0);
    chk("lat_edge2_ch", out_ch, 2);
    chk("lat_edge2_cnt2", cnt_of(2), 0);
    tick();
    chk("lat_edge3_valid", out_valid, 0);

    // Fill ch1 with out_ready low
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      put_valid = 4'b0010;
      put_data[1*WIDTH +: WIDTH] = 32'h100 + i;
      tick();
    end
    chk("fill_cnt1_7", cnt_of(1), 7);
    chk("fill_full1_0", full[1], 0);
    chk("fill_rdy1_1", put_ready[1], 1);
    chk("fill_out_data", out_data, 32'h100);
    put_data[1*WIDTH +: WIDTH] = 32'h108;
    tick();
    chk("fill_cnt1_8", cnt_of(1), 8);
    chk("fill_full1_1", full[1], 1);
    chk("fill_rdy1_0", put_ready[1], 0);
    put_valid = 4'b1010;
    put_data[1*WIDTH +: WIDTH] = 32'h1FF;
    put_data[3*WIDTH +: WIDTH] = 32'h300;
    tick();
    put_valid = '0;
    chk("bp_cnt1_hold", cnt_of(1), 8);
    chk("bp_cnt3_acc", cnt_of(3), 1);
    chk("hold_data", out_data, 32'h100);
    chk("hold_ch", out_ch, 1);

    // Drain: ch3 comes next (scan starts after ch1), then ch1 in order
    out_ready = 1'b1;
    tick();
    chk("drain_ch3", out_ch, 3);
    chk("drain_ch3_data", out_data, 32'h300);
    tick();
    chk("drain_ch1", out_ch, 1);
    chk("drain_ch1_data", out_data, 32'h101);
    chk("drain_cnt1", cnt_of(1), 7);
    for (int i = 0; i < 7; i++) tick();
    chk("drain_last_data", out_data, 32'h108);
    tick();
    chk("drain_done_valid", out_valid, 0);
    chk("drain_done_empty", empty, 4'b1111);

    // Fairness: 2 words per channel, grant order 0,1,2,3,0,1,2,3
    do_reset();
    for (int k = 0; k < 2; k++) begin
      put_valid = 4'b1111;
      for (int c = 0; c < NUM_CH; c++) put_data[c*WIDTH +: WIDTH] = 32'h10 * c + k;
      tick();
    end
    put_valid = '0;
    chk("rr_p0_valid", out_valid, 1);
    chk("rr_p0_ch", out_ch, 0);
    chk("rr_p0_data", out_data, 32'h00);
    out_ready = 1'b1;
    for (int p = 1; p < 8; p++) begin
      tick();
      chk($sformatf("rr_p%0d_valid", p), out_valid, 1);
      chk($sformatf("rr_p%0d_ch", p), out_ch, p % 4);
      chk($sformatf("rr_p%0d_data", p), out_data, 32'h10 * (p % 4) + p / 4);
    end
    tick();
    chk("rr_end_valid", out_valid, 0);
    chk("rr_end_count", count, 0);

    // Flush a full ch0 with a simultaneous put
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      put_valid = 4'b0001;
      put_data[0 +: WIDTH] = 32'h200 + i;
      tick();
    end
    chk("fl_full0", full[0], 1);
`ifdef IVL_UVM_MBX_WMARK_EN
    chk("wm_full0", wm_of(0), 8);
`endif
    put_data[0 +: WIDTH] = 32'h2FF;
    flush = 4'b0001;
    #1;
    chk("fl_rdy0", put_ready[0], 0);
    tick();
    flush = '0;
    put_valid = '0;
    chk("fl_cnt0", cnt_of(0), 0);
    chk("fl_empty0", empty[0], 1);
    chk("fl_out_data", out_data, 32'h200);
    chk("fl_out_valid", out_valid, 1);
`ifdef IVL_UVM_MBX_WMARK_EN
    chk("wm_flushed", wm_of(0), 0);
`endif
    out_ready = 1'b1;
    tick();
    chk("fl_no_ch0_word", out_valid, 0);

`ifdef IVL_UVM_MBX_WMARK_EN
    // Occupy the output register with a ch1 word, then put 5 on ch0
    out_ready = 1'b0;
    put_valid = 4'b0010;
    put_data[1*WIDTH +: WIDTH] = 32'h55;
    tick();
    put_valid = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      put_valid = 4'b0001;
      put_data[0 +: WIDTH] = 32'h400 + i;
      tick();
    end
    put_valid = '0;
    chk("wm_cnt5", cnt_of(0), 5);
    chk("wm_5", wm_of(0), 5);
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("wm_drained_cnt", cnt_of(0), 0);
    chk("wm_persist", wm_of(0), 5);
    flush = 4'b0001;
    tick();
    flush = '0;
    chk("wm_flush_clr", wm_of(0), 0);
`endif

    // Asynchronous reset mid-burst
    out_ready = 1'b1;
    put_valid = 4'b1111;
    for (int c = 0; c < NUM_CH; c++) put_data[c*WIDTH +: WIDTH] = 32'hC0 + c;
    tick();
    tick();
    chk("ar_pre_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_data", out_data, 0);
    chk("ar_ch", out_ch, 0);
    chk("ar_count", count, 0);
    chk("ar_empty", empty, 4'b1111);
`ifdef IVL_UVM_MBX_WMARK_EN
    chk("ar_wmark", wmark, 0);
`endif
    put_valid = '0;
    tick();
    rst = 1'b0;
    tick();
    chk("ar_post_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ivl_uvm_mbx_array.md
Name: ivl_uvm_mbx_array

Overview:
- Parametrised, multi-channel, bounded mailbox in hardware form, with NUM_CH independent FIFO channels.
- Each channel has its own valid/ready put port.
- All channels merge onto one registered get stream using round-robin arbitration, and each output word is tagged with its source channel.
- Sits between multiple ivl_uvm producer components (monitors/drivers) and a single consumer (scoreboard/DUT-side bridge).
- Generalises the single unbounded mailbox to N bounded channels with backpressure, per-channel flush and occupancy.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- DEPTH, 8, entries per channel; power of 2, >=2.
- NUM_CH, 4, number of put channels (>=2).
- Derived: AW = log2(DEPTH); CW = max(1, log2(NUM_CH)).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- put_valid  in  NUM_CH  per-channel write request.
- put_ready  out  NUM_CH  per-channel write accept.
- put_data  in  NUM_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- flush  in  NUM_CH  per-channel synchronous clear.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  WIDTH  word at the head of the output stream.
- out_ch  out  CW  source channel of out_data.
- count  out  NUM_CH*(AW+1)  per-channel occupancy, 0..DEPTH; excludes the output register.
- empty  out  NUM_CH  count==0, per channel.
- full  out  NUM_CH  count==DEPTH, per channel.

Behaviour:
- Reset (async assert, sync release):
  - All channel pointers and counts = 0.
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer last=NUM_CH-1, so channel 0 wins first.
  - Reset mid-transfer discards all data.
- Put:
  - put_ready[c] = !full[c] && !flush[c]. It is independent of a same-cycle pop, so there is no full pass-through.
  - Write fires when put_valid[c] && put_ready[c]. The word is stored at wptr[c], which wraps modulo DEPTH.
- Load condition: load = !out_valid || out_ready.
- Arbitration (when load is true and at least one channel is non-empty):
  - Winner = first non-empty channel scanning last+1, last+2, ... modulo NUM_CH.
  - The winner's head word goes to out_data, its index to out_ch. out_valid is set to 1, rptr[winner] advances and last = winner.
  - If no channel is non-empty and out_ready is high, out_valid clears to 0.
- Eligibility: a word written in cycle N is eligible for arbitration in cycle N+1. Minimum put-to-out_valid latency is 2 edges.
- Output hold: while out_valid && !out_ready, out_data and out_ch hold stable. No channel is popped and last does not change.
- Same-cycle push and pop on one channel: count unchanged, both pointers advance.
- Count updates: count[c] += push − pop. A push alone on a full channel is impossible (put_ready low).
- Flush[c]:
  - Next edge sets wptr[c] = rptr[c] = 0 and count[c] = 0.
  - Flush overrides a same-cycle push (put_ready low) and a same-cycle pop. Channel c is excluded from arbitration that cycle.
  - The output register is unaffected even if it holds a channel-c word.
- Backpressure: each channel blocks only itself. Other channels continue to accept puts.
- Fairness: with all channels continuously non-empty and out_ready=1, the grant order is 0,1,...,NUM_CH-1,0,... and one word leaves per cycle.

Optional Feature:
- Macro: IVL_UVM_MBX_WMARK_EN.
- When defined, adds output port wmark (NUM_CH*(AW+1)): the per-channel high-water mark of count.
  - Reset to 0.
  - Updated each edge to max(wmark, next count).
  - Cleared to 0 by flush[c].
- When undefined, the wmark port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset then idle → out_valid=0, count all 0, empty=4'b1111, full=0, put_ready=4'b1111.
- Put 0xA0 on ch2 at cycle 0, out_ready=1 → out_valid=1 at edge 2 with out_data=0xA0, out_ch=2; count[2] returns to 0.
- Hold out_ready=0, put 8 words on ch1 → count[1]=7, full[1]=0 after the first word is loaded into the output register. Put a 9th word → full[1]=1, put_ready[1]=0. Put on ch3 is still accepted.
- Preload 2 words on every channel, then out_ready=1 → out_ch sequence 0,1,2,3,0,1,2,3 on consecutive cycles with no bubbles.
- ch0 full (8 words), assert flush[0] together with put_valid[0] → next cycle count[0]=0, the put is not accepted, and no ch0 word appears except one already in the output register.
- With IVL_UVM_MBX_WMARK_EN, put 5 then drain → wmark[0]=5 persists after draining; flush[0] → wmark[0]=0. Assert rst mid-burst → all outputs return to reset values immediately (asynchronously).
